// File: rtl/riscv_pkg.sv
// Shared branch encodings and the branch-resolve FSM state type.
package riscv_pkg;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam int unsigned FLUSH_CNT_W = 3;

    typedef enum logic [1:0] {
        BR_IDLE     = 2'd0,
        BR_REDIRECT = 2'd1,
        BR_FLUSH    = 2'd2
    } br_state_e;

endpackage

// File: rtl/branch_cond.sv
// Combinational branch predicate from funct3 and the SUB flags of rs1-rs2.
module branch_cond
    import riscv_pkg::*;
(
    input  logic [2:0] i_funct3,
    input  logic       i_zero,
    input  logic       i_negative,
    input  logic       i_overflow,
    input  logic       i_carry,
    output logic       o_taken_c,
    output logic       o_illegal_c
);

    logic w_lt;

    always_comb begin
        w_lt        = i_negative ^ i_overflow;
        o_taken_c   = 1'b0;
        o_illegal_c = 1'b0;
        case (i_funct3)
            F3_BEQ:  o_taken_c = i_zero;
            F3_BNE:  o_taken_c = ~i_zero;
            F3_BLT:  o_taken_c = w_lt;
            F3_BGE:  o_taken_c = ~w_lt;
            // carry set means no borrow, i.e. rs1 >= rs2 unsigned
            F3_BLTU: o_taken_c = ~i_carry;
            F3_BGEU: o_taken_c = i_carry;
            default: o_illegal_c = 1'b1;
        endcase
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// EX-stage branch/jump resolution: redirect to fetch, flush sequencing, event counters.
module branch_resolve_unit
    import riscv_pkg::*;
#(
    parameter int unsigned XLEN         = 32,
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter int unsigned CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ex_valid_i,
    input  logic             ex_branch_i,
    input  logic             ex_jump_i,
    input  logic [2:0]       funct3_i,
    input  logic             zero_i,
    input  logic             negative_i,
    input  logic             overflow_i,
    input  logic             carry_i,
    input  logic [XLEN-1:0]  target_i,
    input  logic             stall_i,
    output logic             redirect_o,
    output logic [XLEN-1:0]  redirect_pc_o,
    output logic             flush_if_id_o,
    output logic             flush_id_ex_o,
    output logic             taken_o,
    output logic             illegal_o,
    output logic             busy_o,
    output logic [CNT_W-1:0] branch_cnt_o,
    output logic [CNT_W-1:0] redir_cnt_o
);

    br_state_e              r_state;
    br_state_e              w_state_nxt;
    logic [FLUSH_CNT_W-1:0] r_flush_cnt;

    logic w_cond_taken;
    logic w_cond_illegal;
    logic w_resolve;
    logic w_is_branch;
    logic w_take;

    logic w_redirect_nxt;
    logic w_flush_if_id_nxt;
    logic w_flush_id_ex_nxt;
    logic w_busy_nxt;

    logic             r_redirect;
    logic             r_flush_if_id;
    logic             r_flush_id_ex;
    logic             r_busy;
    logic             r_taken;
    logic             r_illegal;
    logic [XLEN-1:0]  r_redirect_pc;
    logic [CNT_W-1:0] r_branch_cnt;
    logic [CNT_W-1:0] r_redir_cnt;

    branch_cond u_branch_cond (
        .i_funct3    (funct3_i),
        .i_zero      (zero_i),
        .i_negative  (negative_i),
        .i_overflow  (overflow_i),
        .i_carry     (carry_i),
        .o_taken_c   (w_cond_taken),
        .o_illegal_c (w_cond_illegal)
    );

    // Only IDLE resolves; anything seen in REDIRECT/FLUSH is wrong-path.
    assign w_resolve   = (r_state == BR_IDLE) & ex_valid_i & ~stall_i & (ex_branch_i | ex_jump_i);
    assign w_is_branch = ex_branch_i & ~ex_jump_i;
    assign w_take      = w_resolve & (ex_jump_i | w_cond_taken);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= BR_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            BR_IDLE: begin
                if (w_take) w_state_nxt = BR_REDIRECT;
            end
            BR_REDIRECT: begin
                if (!stall_i) w_state_nxt = (FLUSH_CYCLES > 1) ? BR_FLUSH : BR_IDLE;
            end
            BR_FLUSH: begin
                if (r_flush_cnt <= FLUSH_CNT_W'(1)) w_state_nxt = BR_IDLE;
            end
            default: w_state_nxt = BR_IDLE;
        endcase
    end

    always_comb begin
        w_redirect_nxt    = 1'b0;
        w_flush_if_id_nxt = 1'b0;
        w_flush_id_ex_nxt = 1'b0;
        w_busy_nxt        = 1'b0;
        case (w_state_nxt)
            BR_REDIRECT: begin
                w_redirect_nxt    = 1'b1;
                w_flush_if_id_nxt = 1'b1;
                w_flush_id_ex_nxt = 1'b1;
                w_busy_nxt        = 1'b1;
            end
            BR_FLUSH: begin
                w_flush_if_id_nxt = 1'b1;
                w_busy_nxt        = 1'b1;
            end
            default: ;
        endcase
    end

    // Remaining FLUSH cycles; loaded as REDIRECT is left, free-running through stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_flush_cnt <= '0;
        end else if (r_state == BR_REDIRECT && !stall_i) begin
            r_flush_cnt <= FLUSH_CNT_W'(FLUSH_CYCLES - 1);
        end else if (r_state == BR_FLUSH) begin
            r_flush_cnt <= r_flush_cnt - FLUSH_CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_redirect    <= 1'b0;
            r_flush_if_id <= 1'b0;
            r_flush_id_ex <= 1'b0;
            r_busy        <= 1'b0;
            r_taken       <= 1'b0;
            r_illegal     <= 1'b0;
            r_redirect_pc <= '0;
            r_branch_cnt  <= '0;
            r_redir_cnt   <= '0;
        end else begin
            r_redirect    <= w_redirect_nxt;
            r_flush_if_id <= w_flush_if_id_nxt;
            r_flush_id_ex <= w_flush_id_ex_nxt;
            r_busy        <= w_busy_nxt;
            r_taken       <= w_take;
            r_illegal     <= w_resolve & w_is_branch & w_cond_illegal;
            if (w_take) begin
                r_redirect_pc <= target_i;
                r_redir_cnt   <= r_redir_cnt + CNT_W'(1);
            end
            if (w_resolve && w_is_branch) begin
                r_branch_cnt <= r_branch_cnt + CNT_W'(1);
            end
        end
    end

    assign redirect_o    = r_redirect;
    assign redirect_pc_o = r_redirect_pc;
    assign flush_if_id_o = r_flush_if_id;
    assign flush_id_ex_o = r_flush_id_ex;
    assign taken_o       = r_taken;
    assign illegal_o     = r_illegal;
    assign busy_o        = r_busy;
    assign branch_cnt_o  = r_branch_cnt;
    assign redir_cnt_o   = r_redir_cnt;

endmodule
